modport_fifo: RTL and testbench

MODPORT_FIFO -- requirements
Module: modport_fifo

---
 rtl/modport_fifo.sv | 76 +++++++
 tb/tb_modport_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/modport_fifo.sv
// Synchronous single-clock FIFO with registered read data and count-decoded
// full/empty/almost flags.
module modport_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_wren,
    input  logic              i_rden,
    input  logic [DATA_W-1:0] i_wrdata,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_alm_full,
    output logic              o_alm_empty,
    output logic [DATA_W-1:0] o_rddata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LVL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic              wr_ok;
    logic              rd_ok;

    // The rstn port is active-high despite its name.
    assign wr_ok = i_wren && !o_full;
    assign rd_ok = i_rden && !o_empty;

    assign o_full      = (count == FULL_CNT);
    assign o_empty     = (count == '0);
    assign o_alm_full  = (count >= AF_CNT);
    assign o_alm_empty = (count <= AE_CNT);

    // NOTE: the storage array has no reset; resetting the pointers and count
    // discards its contents logically and keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (!rstn && wr_ok) begin
            mem[wptr] <= i_wrdata;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so that the
    // read of mem[rptr] sees the pre-edge value, never the word being written.
    always_ff @(posedge clk) begin
        if (rstn) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            o_rddata <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_ok) begin
                rptr     <= rptr + AW'(1);
                o_rddata <= mem[rptr];
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_modport_fifo.sv
// Directed self-checking bench for modport_fifo at default parameters
// (DATA_W=128, DEPTH=16, AF_LVL=14, AE_LVL=2).
module tb_modport_fifo;

    localparam int DATA_W = 128;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic              i_wren;
    logic              i_rden;
    logic [DATA_W-1:0] i_wrdata;
    logic              o_full;
    logic              o_empty;
    logic              o_alm_full;
    logic              o_alm_empty;
    logic [DATA_W-1:0] o_rddata;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    modport_fifo dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_wren     (i_wren),
        .i_rden     (i_rden),
        .i_wrdata   (i_wrdata),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_alm_full (o_alm_full),
        .o_alm_empty(o_alm_empty),
        .o_rddata   (o_rddata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Flag expectations from the bench's own occupancy count.
    task automatic check_flags(input string tag);
        check({tag, " full"},      DATA_W'(o_full),      DATA_W'(exp_cnt == 16));
        check({tag, " empty"},     DATA_W'(o_empty),     DATA_W'(exp_cnt == 0));
        check({tag, " alm_full"},  DATA_W'(o_alm_full),  DATA_W'(exp_cnt >= 14));
        check({tag, " alm_empty"}, DATA_W'(o_alm_empty), DATA_W'(exp_cnt <= 2));
    endtask

    // One clock with the given requests; outputs are sampled 1 time unit
    // after the rising edge. Returns whether the read was accepted.
    task automatic cycle(input logic wr, input logic rd,
                         input logic [DATA_W-1:0] data, output logic rd_acc);
        logic wr_acc;
        wr_acc   = wr && (exp_cnt != DEPTH);
        rd_acc   = rd && (exp_cnt != 0);
        i_wren   = wr;
        i_rden   = rd;
        i_wrdata = data;
        @(posedge clk);
        #1;
        i_wren = 1'b0;
        i_rden = 1'b0;
        if (wr_acc && !rd_acc) exp_cnt++;
        if (rd_acc && !wr_acc) exp_cnt--;
    endtask

    task automatic do_reset(input logic wr, input logic rd);
        rstn     = 1'b1;
        i_wren   = wr;
        i_rden   = rd;
        i_wrdata = 'hFFFF;
        @(posedge clk);
        #1;
        rstn    = 1'b0;
        i_wren  = 1'b0;
        i_rden  = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        logic ra;
        int   rd_idx;

        rstn     = 1'b1;
        i_wren   = 1'b0;
        i_rden   = 1'b0;
        i_wrdata = '0;
        do_reset(1'b0, 1'b0);
        do_reset(1'b0, 1'b0);

        // Reset then idle
        cycle(1'b0, 1'b0, '0, ra);
        check_flags("reset");
        check("reset rddata", o_rddata, '0);

        // Fill with 1..16, flags checked at every count
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, 1'b0, DATA_W'(i), ra);
            check_flags($sformatf("fill cnt%0d", i));
        end

        // Write while full is dropped
        cycle(1'b1, 1'b0, 'hDEAD, ra);
        check_flags("wr-full");

        // Drain: each word one cycle after its request, in order
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, 1'b1, '0, ra);
            check($sformatf("drain data%0d", i), o_rddata, DATA_W'(i));
            check_flags($sformatf("drain cnt%0d", exp_cnt));
        end

        // Read while empty is ignored
        cycle(1'b0, 1'b1, '0, ra);
        check("rd-empty rddata", o_rddata, 'h10);
        check_flags("rd-empty");

        // Simultaneous read+write while empty: only the write lands
        cycle(1'b1, 1'b1, 'h55, ra);
        check("rw-empty rddata", o_rddata, 'h10);
        check_flags("rw-empty");

        // Build count 5, then simultaneous rd+wr returns the oldest word
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DATA_W'('h56 + i), ra);
        cycle(1'b1, 1'b1, 'h5A, ra);
        check("rw-cnt5 rddata", o_rddata, 'h55);
        check_flags("rw-cnt5");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, '0, ra);
            check($sformatf("after-rw data%0d", i), o_rddata, DATA_W'('h56 + i));
        end
        check_flags("after-rw drained");

        // Simultaneous read+write while full: read only, count 15
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, DATA_W'('h100 + i), ra);
        check_flags("refill");
        cycle(1'b1, 1'b1, 'hBEEF, ra);
        check("rw-full rddata", o_rddata, 'h100);
        check_flags("rw-full");
        for (int i = 1; i < 16; i++) begin
            cycle(1'b0, 1'b1, '0, ra);
            check($sformatf("post-full data%0d", i), o_rddata, DATA_W'('h100 + i));
        end
        check_flags("post-full drained");

        // Wrap-around: 40 writes interleaved with reads, sequence 0..39
        rd_idx = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, (i % 4) != 0, DATA_W'(i), ra);
            if (ra) begin
                check($sformatf("wrap data%0d", rd_idx), o_rddata, DATA_W'(rd_idx));
                rd_idx++;
            end
        end
        check_flags("wrap mid");
        while (exp_cnt != 0) begin
            cycle(1'b0, 1'b1, '0, ra);
            check($sformatf("wrap data%0d", rd_idx), o_rddata, DATA_W'(rd_idx));
            rd_idx++;
        end
        check("wrap total reads", DATA_W'(rd_idx), DATA_W'(40));
        check_flags("wrap end");

        // Reset at count 10 with concurrent requests: reset wins
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, DATA_W'('h200 + i), ra);
        check_flags("pre-reset cnt10");
        do_reset(1'b1, 1'b1);
        check_flags("mid-reset");
        check("mid-reset rddata", o_rddata, '0);
        cycle(1'b1, 1'b0, 'hA, ra);
        check_flags("post-reset wr");
        cycle(1'b0, 1'b1, '0, ra);
        check("post-reset rddata", o_rddata, 'hA);
        check_flags("post-reset rd");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
